// File: rtl/frame_rot_pkg.sv
// Shared types and sizing for the frame rotator scheduler.
package frame_rot_pkg;

  localparam int unsigned ROWS      = 16;
  localparam int unsigned ROW_W     = 128;
  localparam int unsigned TAG_DEPTH = 2;
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned TAG_W     = $clog2(MAX_REQ);
  localparam int unsigned CNT_W     = $clog2(ROWS);

  // Tags are sized for the largest supported requester count.
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {IN_IDLE, IN_BURST} in_state_e;
  typedef enum logic {OUT_IDLE, OUT_BURST} out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  // Search ptr..N-1 first, then wrap to 0..ptr-1.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && en && req[j] && (IW'(j) >= ptr)) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && en && req[j] && (IW'(j) < ptr)) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/frame_rot_sched.sv
// Shares one ping-pong frame rotator among NUM_REQ sources: grants whole frames,
// streams rows in, and steers rotated rows back to the owning requester.
module frame_rot_sched
  import frame_rot_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  input  logic [NUM_REQ*ROW_W-1:0] req_data_i,
  output logic                     rot_start_o,
  output logic [ROW_W-1:0]         rot_data_o,
  input  logic                     rot_start_i,
  input  logic [ROW_W-1:0]         rot_data_i,
  output logic [NUM_REQ-1:0]       out_vld_o,
  output logic                     out_sof_o,
  output logic [ROW_W-1:0]         out_data_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int unsigned IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(TAG_DEPTH + 1);

  in_state_e  in_state, in_state_d;
  out_state_e out_state, out_state_d;
  cnt_t       in_cnt, in_cnt_d, out_cnt, out_cnt_d;
  tag_t       in_owner, in_owner_d, out_owner, out_owner_d;
  logic       err_q, err_d;

  tag_t             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_en, grant, pop, in_open;

  // A start is accepted only with a tag queued and the output side free or on its last row.
  assign pop     = rot_start_i && (occ != '0) &&
                   ((out_state == OUT_IDLE) || (out_cnt == cnt_t'(ROWS - 1)));
  assign in_open = (in_state == IN_IDLE) || (in_cnt == cnt_t'(ROWS - 1));
  assign arb_en  = !rst && in_open && ((occ != OCC_W'(TAG_DEPTH)) || pop);
  assign grant   = |arb_gnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_i),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign gnt_o       = arb_gnt;
  assign rot_start_o = grant;
  assign busy_o      = (in_state == IN_BURST) || (occ != '0);
  assign err_o       = err_q;
  assign out_sof_o   = (out_state == OUT_BURST) && (out_cnt == '0);
  assign out_data_o  = (out_state == OUT_BURST) ? rot_data_i : '0;

  always_comb begin
    rot_data_o = '0;
    out_vld_o  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if ((in_state == IN_BURST) && (in_owner == tag_t'(k)))
        rot_data_o = req_data_i[k*ROW_W +: ROW_W];
      out_vld_o[k] = (out_state == OUT_BURST) && (out_owner == tag_t'(k));
    end
  end

  // Input sequencer: a grant on the last row chains straight into the next burst.
  always_comb begin
    in_state_d = in_state;
    in_cnt_d   = in_cnt;
    in_owner_d = in_owner;
    if (grant) begin
      in_state_d = IN_BURST;
      in_cnt_d   = '0;
      in_owner_d = tag_t'(arb_idx);
    end else if (in_state == IN_BURST) begin
      if (in_cnt == cnt_t'(ROWS - 1)) begin
        in_state_d = IN_IDLE;
        in_cnt_d   = '0;
      end else begin
        in_cnt_d = in_cnt + cnt_t'(1);
      end
    end
  end

  // Output sequencer and sticky error on any start that cannot be accepted.
  always_comb begin
    out_state_d = out_state;
    out_cnt_d   = out_cnt;
    out_owner_d = out_owner;
    err_d       = err_q;
    if (rot_start_i && !pop) err_d = 1'b1;
    if (pop) begin
      out_state_d = OUT_BURST;
      out_cnt_d   = '0;
      out_owner_d = tag_mem[rd_ptr];
    end else if (out_state == OUT_BURST) begin
      if (out_cnt == cnt_t'(ROWS - 1)) begin
        out_state_d = OUT_IDLE;
        out_cnt_d   = '0;
      end else begin
        out_cnt_d = out_cnt + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state  <= IN_IDLE;
      in_cnt    <= '0;
      in_owner  <= '0;
      out_state <= OUT_IDLE;
      out_cnt   <= '0;
      out_owner <= '0;
      err_q     <= 1'b0;
    end else begin
      in_state  <= in_state_d;
      in_cnt    <= in_cnt_d;
      in_owner  <= in_owner_d;
      out_state <= out_state_d;
      out_cnt   <= out_cnt_d;
      out_owner <= out_owner_d;
      err_q     <= err_d;
    end
  end

  // Tag FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (grant) wr_ptr <= (wr_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= (rd_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (grant && !pop)      occ <= occ + OCC_W'(1);
      else if (!grant && pop) occ <= occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= tag_t'(arb_idx);
  end

endmodule

// File: tb/tb_frame_rot_sched.sv
// Bench for frame_rot_sched: acts as the requesters and the rotator, and checks
// every cycle against a queue-based model of grants, tags and frame timing.
module tb_frame_rot_sched;
  import frame_rot_pkg::*;

  localparam int NR     = 4;
  localparam int ELEM_W = ROW_W / ROWS;
  localparam int SLOTS  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR-1:0]       req_i, gnt_o, out_vld_o;
  logic [NR*ROW_W-1:0] req_data_i;
  logic                rot_start_o, rot_start_i, out_sof_o, busy_o, err_o;
  logic [ROW_W-1:0]    rot_data_o, rot_data_i, out_data_o;

  frame_rot_sched #(.NUM_REQ(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .req_data_i  (req_data_i),
    .rot_start_o (rot_start_o),
    .rot_data_o  (rot_data_o),
    .rot_start_i (rot_start_i),
    .rot_data_i  (rot_data_i),
    .out_vld_o   (out_vld_o),
    .out_sof_o   (out_sof_o),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state
  logic [NR-1:0]    req_mask;
  int               rr, in_left, in_slot, out_left, out_slot, next_slot;
  int               tag_q[$];
  logic             err_m;
  logic [ROW_W-1:0] fr_mem [SLOTS][ROWS];
  int               fr_owner [SLOTS];
  int               fr_ready [SLOTS];
  // rotator state
  int               rot_q[$];
  int               rot_left, rot_slot;
  // stimulus knobs and observations
  bit               refill, drop_en, hold, spur, idx_data;
  int               new_prob;
  int               obs_gnts, gnt_cyc, sof_cyc;
  int               gq[$];

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Row r of the rotated frame: element c is element r of input row c.
  function automatic logic [ROW_W-1:0] trow(input int slot, input int r);
    logic [ROW_W-1:0] res;
    res = '0;
    for (int c = 0; c < ROWS; c++)
      res[c*ELEM_W +: ELEM_W] = fr_mem[slot][c][r*ELEM_W +: ELEM_W];
    return res;
  endfunction

  task automatic model_reset();
    req_mask = '0;
    rr       = 0;
    in_left  = 0;
    out_left = 0;
    err_m    = 1'b0;
    rot_left = 0;
    tag_q.delete();
    rot_q.delete();
  endtask

  task automatic cycle();
    logic             rs, rs_real, pop_ok, free, exp_sof, exp_busy;
    logic [NR-1:0]    eg, exp_vld;
    logic [ROW_W-1:0] exp_rd, exp_od;
    int               k, slot;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (!req_mask[i] && ($urandom_range(99) < new_prob)) req_mask[i] = 1'b1;
      else if (req_mask[i] && drop_en && ($urandom_range(31) == 0)) req_mask[i] = 1'b0;
    end
    req_i = req_mask;
    for (int i = 0; i < NR; i++) req_data_i[i*ROW_W +: ROW_W] = rand_row();
    if (in_left > 0) req_data_i[fr_owner[in_slot]*ROW_W +: ROW_W] = fr_mem[in_slot][ROWS-in_left];
    rs = 1'b0;
    rs_real = 1'b0;
    if (spur) begin
      rs   = 1'b1;
      spur = 1'b0;
    end else if (!hold && (rot_q.size() > 0) && (fr_ready[rot_q[0]] <= cyc) && (rot_left <= 1)) begin
      rs      = 1'b1;
      rs_real = 1'b1;
    end
    rot_start_i = rs;
    rot_data_i  = (rot_left > 0) ? trow(rot_slot, ROWS - rot_left) : rand_row();

    pop_ok = rs && (tag_q.size() > 0) && (out_left <= 1);
    free   = (tag_q.size() < TAG_DEPTH) || pop_ok;
    k      = -1;
    if (free && (in_left <= 1))
      for (int i = 0; i < NR; i++) begin
        int j = (rr + i) % NR;
        if ((k < 0) && req_mask[j]) k = j;
      end
    eg = '0;
    if (k >= 0) eg[k] = 1'b1;
    exp_rd   = (in_left > 0) ? fr_mem[in_slot][ROWS-in_left] : '0;
    exp_vld  = '0;
    if (out_left > 0) exp_vld[fr_owner[out_slot]] = 1'b1;
    exp_sof  = (out_left == ROWS);
    exp_od   = (out_left > 0) ? trow(out_slot, ROWS - out_left) : '0;
    exp_busy = (in_left > 0) || (tag_q.size() > 0);

    @(negedge clk);
    check("gnt", gnt_o, eg);
    check("rot_start", rot_start_o, k >= 0);
    check("rot_data", rot_data_o, exp_rd);
    check("out_vld", out_vld_o, exp_vld);
    check("out_sof", out_sof_o, exp_sof);
    check("out_data", out_data_o, exp_od);
    check("busy", busy_o, exp_busy);
    check("err", err_o, err_m);
    if (|gnt_o) begin
      obs_gnts++;
      if (gnt_cyc < 0) gnt_cyc = cyc;
      for (int i = 0; i < NR; i++) if (gnt_o[i]) gq.push_back(i);
    end
    if (out_sof_o && (sof_cyc < 0)) sof_cyc = cyc;

    if (rs && !pop_ok) err_m = 1'b1;
    if (pop_ok) begin
      out_slot = tag_q.pop_front();
      out_left = ROWS;
    end else if (out_left > 0) begin
      out_left--;
    end
    if (in_left > 0) in_left--;
    if (k >= 0) begin
      slot      = next_slot;
      next_slot = (next_slot + 1) % SLOTS;
      fr_owner[slot] = k;
      fr_ready[slot] = cyc + ROWS;
      for (int r = 0; r < ROWS; r++) fr_mem[slot][r] = idx_data ? ROW_W'(r) : rand_row();
      tag_q.push_back(slot);
      rot_q.push_back(slot);
      in_slot = slot;
      in_left = ROWS;
      rr      = (k + 1) % NR;
      if (!refill) req_mask[k] = 1'b0;
    end
    if (rot_left > 0) rot_left--;
    if (rs_real) begin
      rot_slot = rot_q.pop_front();
      rot_left = ROWS;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt_o, '0);
    check({tag, "_rot_start"}, rot_start_o, 1'b0);
    check({tag, "_rot_data"}, rot_data_o, '0);
    check({tag, "_out_vld"}, out_vld_o, '0);
    check({tag, "_out_sof"}, out_sof_o, 1'b0);
    check({tag, "_out_data"}, out_data_o, '0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  task automatic mid_reset();
    int guard = 0;
    while ((in_left != ROWS - 7) && (guard < 200)) begin
      cycle();
      guard++;
    end
    check("mid_burst_reached", guard < 200, 1'b1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    req_i       = '1;
    rot_start_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_all_zero("in_reset");
    end
    req_i       = '0;
    rot_start_i = 1'b0;
    rst         = 1'b0;
    model_reset();
  endtask

  initial begin
    int rr0, first;
    rst = 1'b1;
    req_i = '0;
    req_data_i = '0;
    rot_start_i = 1'b0;
    rot_data_i = '0;
    next_slot = 0;
    {refill, drop_en, hold, spur, idx_data} = '0;
    new_prob = 0;
    obs_gnts = 0;
    gnt_cyc = -1;
    sof_cyc = -1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // single frame from requester 2, row r = r
    idx_data = 1'b1;
    req_mask = 4'b0100;
    repeat (40) cycle();
    check("single_latency", 32'(sof_cyc - gnt_cyc), 32'(ROWS + 1));
    idx_data = 1'b0;

    // all requesters continuously
    rr0 = rr;
    gq.delete();
    refill = 1'b1;
    req_mask = '1;
    repeat (90) cycle();
    refill = 1'b0;
    req_mask = '0;
    repeat (70) cycle();
    check("rr_count", gq.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      check("rr_order", gq[i], (rr0 + i) % NR);

    // tag full: rotator held after two grants
    hold = 1'b1;
    obs_gnts = 0;
    req_mask = 4'b0111;
    repeat (50) cycle();
    check("full_grants", obs_gnts, 2);
    hold = 1'b0;
    cycle();
    check("release_gnt", |gnt_o, 1'b1);
    check("release_start", rot_start_i, 1'b1);
    repeat (80) cycle();

    // spurious start with nothing outstanding
    spur = 1'b1;
    cycle();
    cycle();
    check("spur_err", err_o, 1'b1);
    repeat (6) cycle();
    check("spur_err_sticky", err_o, 1'b1);

    // reset in the middle of an input burst
    refill = 1'b1;
    req_mask = '1;
    mid_reset();
    check("post_reset_busy", busy_o, 1'b0);
    req_mask = '1;
    refill = 1'b0;
    cycle();
    check("post_reset_gnt", gnt_o, 4'b0001);
    repeat (70) cycle();

    // randomized traffic with drops and rotator back-pressure
    new_prob = 20;
    drop_en  = 1'b1;
    for (int n = 0; n < 50; n++) begin
      hold = ($urandom_range(3) == 0);
      repeat (16) cycle();
    end
    hold = 1'b0;
    new_prob = 0;
    drop_en = 1'b0;
    first = cyc;
    repeat (90) cycle();
    check("drained_busy", busy_o, 1'b0);
    check("drain_cycles", cyc - first, 90);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
